// File: rtl/conv_feeder_pkg.sv
// Shared types and constants for the convolution stream feeder.
// FSM encoding and distribution-mode selectors.
package conv_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_GUARD
  } feed_state_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_BCAST = 1;

endpackage

// File: rtl/conv_feeder_fifo.sv
// Synchronous FIFO with occupancy count.
// Head word is presented combinationally on dout.
module conv_feeder_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/axis_conv_stream_feeder.sv
// AXI-Stream to multi-channel feeder: buffers words, then serves
// them round-robin or broadcast with a one-cycle guard per serve.
module axis_conv_stream_feeder
  import conv_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0
) (
  input  logic                   S_AXIS_ACLK,
  input  logic                   S_AXIS_ARESETN,
  input  logic [DATA_W-1:0]      S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0]    S_AXIS_TSTRB,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic [NUM_CH-1:0]      ch_needs_data,
  output logic [DATA_W-1:0]      ch_data,
  output logic                   ch_last,
  output logic [NUM_CH-1:0]      ch_served,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            frame_count
);

  localparam int SW = DATA_W / 8;
  localparam int FW = DATA_W + SW + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  feed_state_e state_q;
  feed_state_e state_d;

  logic              push;
  logic              pop;
  logic              start;
  logic              go;
  logic [FW-1:0]     din;
  logic [FW-1:0]     head;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] win_mask;
  logic [NUM_CH-1:0] mask_q;
  logic [PW-1:0]     rr_q;
  logic [PW-1:0]     rr_win;
  logic [PW-1:0]     idx;
  logic              rr_hit;
  logic [15:0]       frame_q;
  logic              unused_strb;

  assign push    = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop     = (state_q == ST_SERVE);
  assign din     = {S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA};
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign elig    = ch_enable & ch_needs_data;

  assign unused_strb = ^head[DATA_W +: SW];

  conv_feeder_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (S_AXIS_ACLK),
    .rst_n (S_AXIS_ARESETN),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );

  // Search upward from the slot after the last winner.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = rr_q;
    idx    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = PW'((int'(rr_q) + k) % NUM_CH);
      if (!rr_hit && elig[idx]) begin
        rr_hit = 1'b1;
        rr_win = idx;
      end
    end
  end

  always_comb begin
    win_mask = '0;
    if (MODE == MODE_BCAST) begin
      win_mask = ch_enable;
      go = (|ch_enable) && (elig == ch_enable);
    end else begin
      win_mask[rr_win] = 1'b1;
      go = rr_hit;
    end
    go = go && (cnt != '0);
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_SERVE;
          start   = 1'b1;
        end
      end
      ST_SERVE: state_d = ST_GUARD;
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Word, winner mask and pointer are latched on SERVE entry so
  // enable changes during SERVE/GUARD cannot alter the word in flight.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state_q       <= ST_IDLE;
      S_AXIS_TREADY <= 1'b0;
      ch_served     <= '0;
      ch_data       <= '0;
      ch_last       <= 1'b0;
      mask_q        <= '0;
      rr_q          <= PW'(NUM_CH - 1);
      frame_q       <= '0;
    end else begin
      state_q       <= state_d;
      S_AXIS_TREADY <= (cnt_nxt < CW'(DEPTH));
      ch_served     <= (state_q == ST_SERVE) ? mask_q : '0;
      if (start) begin
        ch_data <= head[DATA_W-1:0];
        ch_last <= head[FW-1];
        mask_q  <= win_mask;
        if (MODE == MODE_RR) rr_q <= rr_win;
      end
      if (push && S_AXIS_TLAST) frame_q <= frame_q + 16'd1;
    end
  end

  assign fifo_count  = cnt;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_axis_conv_stream_feeder.sv
// Directed bench: round-robin and broadcast instances of the feeder.
// Expected values are hand-derived from the required behaviour.
module tb_axis_conv_stream_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] r_tdata;
  logic [1:0]  r_tstrb;
  logic        r_tlast;
  logic        r_tvalid;
  logic        r_tready;
  logic [3:0]  r_en;
  logic [3:0]  r_need;
  logic [15:0] r_data;
  logic        r_last;
  logic [3:0]  r_served;
  logic [4:0]  r_fcount;
  logic [15:0] r_frames;

  logic [15:0] b_tdata;
  logic [1:0]  b_tstrb;
  logic        b_tlast;
  logic        b_tvalid;
  logic        b_tready;
  logic [3:0]  b_en;
  logic [3:0]  b_need;
  logic [15:0] b_data;
  logic        b_last;
  logic [3:0]  b_served;
  logic [4:0]  b_fcount;
  logic [15:0] b_frames;

  axis_conv_stream_feeder #(
    .DATA_W (16),
    .DEPTH  (16),
    .NUM_CH (4),
    .MODE   (0)
  ) u_rr (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA   (r_tdata),
    .S_AXIS_TSTRB   (r_tstrb),
    .S_AXIS_TLAST   (r_tlast),
    .S_AXIS_TVALID  (r_tvalid),
    .S_AXIS_TREADY  (r_tready),
    .ch_enable      (r_en),
    .ch_needs_data  (r_need),
    .ch_data        (r_data),
    .ch_last        (r_last),
    .ch_served      (r_served),
    .fifo_count     (r_fcount),
    .frame_count    (r_frames)
  );

  axis_conv_stream_feeder #(
    .DATA_W (16),
    .DEPTH  (16),
    .NUM_CH (4),
    .MODE   (1)
  ) u_bc (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA   (b_tdata),
    .S_AXIS_TSTRB   (b_tstrb),
    .S_AXIS_TLAST   (b_tlast),
    .S_AXIS_TVALID  (b_tvalid),
    .S_AXIS_TREADY  (b_tready),
    .ch_enable      (b_en),
    .ch_needs_data  (b_need),
    .ch_data        (b_data),
    .ch_last        (b_last),
    .ch_served      (b_served),
    .fifo_count     (b_fcount),
    .frame_count    (b_frames)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    int last_c;
    int acc;
    logic [3:0] orv;

    rst_n    = 1'b0;
    r_tdata  = 16'hAAAA; r_tstrb = 2'b11; r_tlast = 1'b0;
    r_tvalid = 1'b1;     r_en    = 4'hF;  r_need  = 4'h0;
    b_tdata  = 16'h5555; b_tstrb = 2'b11; b_tlast = 1'b0;
    b_tvalid = 1'b1;     b_en    = 4'h0;  b_need  = 4'h0;

    // Reset with TVALID high
    tick(); tick();
    check("rst_tready", 32'(r_tready), 0);
    check("rst_data",   32'(r_data),   0);
    check("rst_last",   32'(r_last),   0);
    check("rst_served", 32'(r_served), 0);
    check("rst_fcount", 32'(r_fcount), 0);
    check("rst_frames", 32'(r_frames), 0);
    check("rst_btready", 32'(b_tready), 0);
    r_tvalid = 1'b0;
    b_tvalid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("rel_tready",  32'(r_tready), 1);
    check("rel_btready", 32'(b_tready), 1);

    // Broadcast: ch0,ch2 enabled, only ch0 requesting
    b_en = 4'b0101; b_need = 4'b0001;
    b_tdata = 16'h5A5A; b_tvalid = 1'b1;
    tick();
    b_tvalid = 1'b0;
    orv = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      orv = orv | b_served;
    end
    check("bc_none",   32'(orv),      0);
    check("bc_fcount", 32'(b_fcount), 1);
    b_need = 4'b0101;
    tick();
    b_en = 4'b0001;
    tick();
    check("bc_served", 32'(b_served), 32'h5);
    check("bc_data",   32'(b_data),   32'h5A5A);
    tick();
    check("bc_pulse1", 32'(b_served), 0);
    check("bc_empty",  32'(b_fcount), 0);
    b_en = 4'b0101; b_need = 4'b0000;

    // Round-robin over 8 words
    r_en = 4'hF; r_need = 4'hF;
    got = 0; last_c = -1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      if (c < 8) begin
        r_tvalid = 1'b1;
        r_tdata  = 16'(c + 1);
      end else begin
        r_tvalid = 1'b0;
      end
      tick();
      if (r_served != 4'h0) begin
        check("rr_ch",   32'(r_served), 32'(1 << (got % 4)));
        check("rr_data", 32'(r_data),   32'(got + 1));
        if (got > 0) check("rr_gap", 32'(c - last_c), 3);
        last_c = c;
        got++;
      end
    end
    r_tvalid = 1'b0;
    check("rr_count", 32'(got), 8);
    tick(); tick(); tick();
    check("rr_empty", 32'(r_fcount), 0);

    // Fill to DEPTH with no requests
    r_need = 4'h0; r_tvalid = 1'b1; acc = 0;
    for (int i = 0; i < 20; i++) begin
      r_tdata = 16'(16'h0100 + acc);
      if (r_tready) acc++;
      tick();
    end
    check("full_acc",    32'(acc),      16);
    check("full_tready", 32'(r_tready), 0);
    check("full_fcount", 32'(r_fcount), 16);
    r_tvalid = 1'b0;
    r_need   = 4'b0001;
    tick();
    r_need = 4'h0;
    tick();
    check("full_serve",  32'(r_served), 1);
    check("full_head",   32'(r_data),   32'h0100);
    check("full_ready1", 32'(r_tready), 1);
    check("full_cnt15",  32'(r_fcount), 15);
    r_need = 4'hF;
    for (int i = 0; i < 200 && r_fcount != 0; i++) tick();
    tick(); tick(); tick();
    check("drain", 32'(r_fcount), 0);
    r_need = 4'h0;

    // Frames: TLAST on words 2 and 5
    for (int i = 0; i < 5; i++) begin
      r_tvalid = 1'b1;
      r_tdata  = 16'(16'h0021 + i);
      r_tlast  = (i == 1 || i == 4);
      tick();
    end
    r_tvalid = 1'b0; r_tlast = 1'b0;
    check("frames2",  32'(r_frames), 2);
    check("frm_fcnt", 32'(r_fcount), 5);
    r_need = 4'hF; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      tick();
      if (r_served != 4'h0) begin
        check("frm_last", 32'(r_last), 32'(got == 1 || got == 4));
        got++;
      end
    end
    check("frm_serves", 32'(got), 5);
    r_need = 4'h0;
    tick(); tick();

    // Frame counter wrap
    force u_rr.frame_q = 16'hFFFF;
    #1;
    release u_rr.frame_q;
    check("wrap_pre", 32'(r_frames), 32'hFFFF);
    r_tvalid = 1'b1; r_tlast = 1'b1; r_tdata = 16'h0077;
    tick();
    r_tvalid = 1'b0; r_tlast = 1'b0;
    check("wrap", 32'(r_frames), 0);
    r_need = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    r_need = 4'h0;
    tick(); tick();

    // Reset during SERVE with 3 buffered words
    for (int i = 0; i < 3; i++) begin
      r_tvalid = 1'b1;
      r_tdata  = 16'(16'h0031 + i);
      tick();
    end
    r_tvalid = 1'b0;
    check("mid_fcnt3", 32'(r_fcount), 3);
    r_need = 4'hF;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_served", 32'(r_served), 0);
    check("mid_fcount", 32'(r_fcount), 0);
    check("mid_data",   32'(r_data),   0);
    check("mid_tready", 32'(r_tready), 0);
    rst_n  = 1'b1;
    r_need = 4'h0;
    tick();
    check("mid_ready",  32'(r_tready), 1);
    check("mid_quiet",  32'(r_served), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_conv_stream_feeder.md
AXIS_CONV_STREAM_FEEDER -- requirements
Module: axis_conv_stream_feeder

Interface
REQ-001 Parameter DATA_W, default 16, is the stream and channel data width in bits.
REQ-002 Parameter DEPTH, default 16, is the FIFO depth in words; it SHALL be a power of two, minimum 2.
REQ-003 Parameter NUM_CH, default 4, is the number of consumer channels, range 1..8.
REQ-004 Parameter MODE, default 0, selects distribution: 0 = round-robin, 1 = broadcast.
REQ-005 S_AXIS_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 S_AXIS_ARESETN  in  1  synchronous, active-low reset.
REQ-007 S_AXIS_TDATA  in  DATA_W  stream data.
REQ-008 S_AXIS_TSTRB  in  DATA_W/8  byte strobes; stored, not interpreted.
REQ-009 S_AXIS_TLAST  in  1  frame end marker.
REQ-010 S_AXIS_TVALID  in  1  upstream word valid.
REQ-011 S_AXIS_TREADY  out  1  block can accept a word.
REQ-012 ch_enable  in  NUM_CH  per-channel enable mask.
REQ-013 ch_needs_data  in  NUM_CH  level request per channel.
REQ-014 ch_data  out  DATA_W  word being served; shared by all channels.
REQ-015 ch_last  out  1  TLAST stored with the word being served.
REQ-016 ch_served  out  NUM_CH  one-cycle pulse per served channel.
REQ-017 fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 frame_count  out  16  count of accepted TLAST words; wraps 0xFFFF->0.

Function
REQ-019 A word SHALL be pushed on every cycle with TVALID=1 and TREADY=1.
REQ-020 TREADY SHALL be a register equal to (next occupancy < DEPTH), so it is never high while the FIFO is full.
REQ-021 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-022 The FSM SHALL have states IDLE, SERVE and GUARD.
REQ-023 Eligibility: channel i is eligible when ch_enable[i]=1 and ch_needs_data[i]=1.
REQ-024 IDLE->SERVE when the FIFO is non-empty and, in MODE 0, at least one channel is eligible; in MODE 1, every enabled channel is eligible and at least one channel is enabled.
REQ-025 On entry to SERVE, ch_data and ch_last SHALL be loaded with the FIFO head word.
REQ-026 In SERVE, ch_served SHALL pulse for exactly one cycle: in MODE 0 for the single winning channel, in MODE 1 for all enabled channels.
REQ-027 In SERVE, the FIFO head SHALL be popped.
REQ-028 SERVE SHALL always go to GUARD, and GUARD SHALL always go to IDLE; this gives consumers one cycle to drop ch_needs_data.
REQ-029 In MODE 0, the winner SHALL be the first eligible channel, searching upward from (last winner+1) mod NUM_CH; after reset the last winner is NUM_CH-1.
REQ-030 ch_data and ch_last SHALL hold their value outside SERVE.
REQ-031 frame_count SHALL increment on push of a word with TLAST=1.
REQ-032 Requests on disabled channels SHALL be ignored; changing ch_enable in SERVE or GUARD SHALL NOT affect the word in flight.

Reset
REQ-033 With S_AXIS_ARESETN=0 at a clock edge, the block SHALL set: FSM=IDLE, FIFO empty, fifo_count=0, TREADY=0, ch_served=0, ch_data=0, ch_last=0, frame_count=0, round-robin pointer=NUM_CH-1.
REQ-034 Reset asserted mid-SERVE SHALL suppress ch_served on that edge and discard all buffered words.
REQ-035 TREADY SHALL rise on the first edge after reset is released.

Structure
REQ-036 Package conv_feeder_pkg SHALL hold the FSM state encoding and the MODE_RR=0 / MODE_BCAST=1 constants.
REQ-037 Buffering SHALL be a sub-module conv_feeder_fifo (synchronous, width DATA_W+DATA_W/8+1, depth DEPTH, with count output).

Verification
REQ-038 Reset with TVALID=1 -> TREADY=0 and all outputs 0; TREADY=1 on the first edge after release.
REQ-039 MODE 0, NUM_CH=4, all channels enabled and requesting, push 0x0001..0x0008 -> served order ch0,1,2,3,0,1,2,3 with data 1..8, one serve every 3 cycles.
REQ-040 DEPTH=16, no requests, TVALID held high -> exactly 16 words accepted, TREADY=0 and fifo_count=16; one serve -> TREADY=1 on the next cycle.
REQ-041 MODE 1, ch_enable=4'b0101, only ch0 requesting -> no serve; ch2 then requests -> ch_served=4'b0101 for 1 cycle, data = head word.
REQ-042 Push 5 words with TLAST on words 2 and 5 -> frame_count=2, ch_last=1 on the 2nd and 5th serves only; preload frame_count to 0xFFFF, one TLAST -> 0.
REQ-043 Assert reset in a SERVE cycle with 3 words buffered -> no ch_served pulse, fifo_count=0 the next cycle.
